uart_text_buffer: RTL and testbench
===================================

// Module: uart_text_buffer
// PURPOSE
//   Upstream feeder for textEngine: receives 8N1 UART bytes, interprets them as a
//   terminal stream and keeps a ROWS x COLS character buffer. textEngine reads the
//   buffer through a synchronous port (charAddress -> charOutput, ASCII) and renders
//   the glyphs into pixelData for the screen driver.
// PARAMETERS
//   CLK_HZ   27000000  system clock frequency
//   BAUD     115200    UART bit rate; BIT_CYC = CLK_HZ/BAUD (floor, 234), HALF = BIT_CYC/2 (117)
//   COLS     16        characters per row
//   ROWS     4         rows; AW = $clog2(ROWS*COLS) (6 at defaults)
// PORTS
//   clk          in   1    system clock, all logic on rising edge
//   reset        in   1    asynchronous, active-high
//   uartRx       in   1    serial input, idle high, asynchronous to clk
//   charAddress  in   AW   read address = row*COLS + col
//   charOutput   out  8    ASCII at charAddress, registered
//   byteValid    out  1    1-cycle pulse: good byte received
//   lastByte     out  8    last good byte (held)
//   rxError      out  1    1-cycle pulse: framing error or false start
// BEHAVIOUR
//   Reset values: charOutput=0x20, byteValid=0, lastByte=0x00, rxError=0, wrPtr=0,
//     RX FSM=IDLE, clear FSM=CLR_ALL (starts on first edge after reset deasserts).
//   Input sync: 2-flop synchronizer on uartRx; all RX logic uses synced value.
//   RX FSM (cycle counter cnt, bit index 0..7):
//     IDLE  : synced rx=0 -> START, cnt=0.
//     START : at cnt=HALF-1 sample; 0 -> DATA, cnt=0; 1 -> rxError pulse, IDLE.
//     DATA  : every BIT_CYC cycles sample one bit, LSB first; after bit 7 -> STOP.
//     STOP  : after BIT_CYC sample; 1 -> byteValid pulse, lastByte=byte, IDLE;
//             0 -> rxError pulse, byte discarded, IDLE (waits for line to idle-high
//             implicitly: next start needs a falling level).
//   Byte handling (same cycle as byteValid):
//     0x20..0x7E : mem[wrPtr]=byte, wrPtr=wrPtr+1, ROWS*COLS-1 wraps to 0.
//     0x0D (CR)  : wrPtr = row start of current row.
//     0x0A (LF)  : wrPtr = start of next row (last row -> row 0); clear FSM
//                  CLR_ROW writes 0x20 to that row's COLS cells, 1 per cycle.
//     0x0C (FF)  : wrPtr=0; CLR_ALL writes 0x20 to all ROWS*COLS cells.
//     others     : ignored, no state change besides byteValid/lastByte.
//   Clear FSM: IDLE, CLR_ROW (COLS cycles), CLR_ALL (ROWS*COLS cycles). Clears
//     finish well before next byte (BIT_CYC*10 cycles); a byte arriving mid-clear
//     is still written, and the clear continues, never skipping a cell.
//   Read port: charOutput <= mem[charAddress] every cycle, 1-cycle latency; forced
//     0x20 while CLR_ALL is active. Same-cycle write/read of one address returns
//     old data. Memory is inferable as single-write, single-read RAM (no reset).
//   Reset mid-byte: partial byte dropped, no pulses, buffer re-cleared after release.
// TESTING
//   1 Release reset, wait 64 cycles, read all 64 addresses -> every charOutput=0x20.
//   2 Send 0x41 at BIT_CYC=234 -> one byteValid pulse, lastByte=0x41; addr 0 reads
//     0x41 one cycle after charAddress=0; wrPtr=1.
//   3 Send 17 printable bytes 'a'..'q' -> addr 0..16 hold them, 'q' at addr 16 (row 1).
//   4 Fill to wrPtr=50, send 0x0A -> wrPtr=0, addrs 0..15 read 0x20, 16..49 intact;
//     then 0x0D after 3 chars -> wrPtr back to 0.
//   5 Stop bit driven low -> rxError pulse, no byteValid, buffer unchanged; 50-cycle
//     low glitch -> rxError pulse, RX returns to IDLE, next byte received correctly.
//   6 Assert reset at DATA bit 4 -> outputs at reset values; after release buffer all
//     0x20 within 64 cycles, next full byte received normally; 0x0C clears likewise.

Source files
------------

// File: rtl/uart_text_buffer.sv
// rtl/uart_text_buffer.sv - 8N1 UART receiver feeding a ROWS x COLS terminal character buffer
module uart_text_buffer #(
  parameter int CLK_HZ = 27000000,
  parameter int BAUD   = 115200,
  parameter int COLS   = 16,
  parameter int ROWS   = 4,
  localparam int AW    = $clog2(ROWS * COLS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          uartRx,
  input  logic [AW-1:0] charAddress,
  output logic [7:0]    charOutput,
  output logic          byteValid,
  output logic [7:0]    lastByte,
  output logic          rxError
);

  localparam int BIT_CYC = CLK_HZ / BAUD;
  localparam int HALF    = BIT_CYC / 2;
  localparam int DEPTH   = ROWS * COLS;
  localparam int CW      = $clog2(BIT_CYC + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {CLR_IDLE, CLR_ROW, CLR_ALL} clr_state_t;

  logic            r_rx_meta, r_rx_sync, r_rx_prev;
  rx_state_t       r_rx_state, w_rx_next;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic            r_byte_valid, r_rx_error;
  logic [7:0]      r_last_byte;
  logic            w_set_valid, w_set_err, w_fall, w_half_done, w_bit_done;

  clr_state_t      r_clr_state, w_clr_next;
  logic [AW-1:0]   r_clr_cnt, r_clr_base;
  logic [AW-1:0]   r_wr_ptr;
  logic [7:0]      r_mem [0:DEPTH-1];
  logic [7:0]      r_char_out;

  logic            w_printable, w_cr, w_lf, w_ff, w_row_go;
  logic            w_byte_we, w_clr_we, w_clr_last, w_we;
  logic [AW-1:0]   w_waddr, w_row_start, w_next_row, w_ptr_inc;
  logic [7:0]      w_wdata;

  assign charOutput = r_char_out;
  assign byteValid  = r_byte_valid;
  assign lastByte   = r_last_byte;
  assign rxError    = r_rx_error;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= uartRx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  // A start needs a falling level, so a low line after a bad stop bit is not re-armed.
  assign w_fall      = r_rx_prev & ~r_rx_sync;
  assign w_half_done = (r_cnt == CW'(HALF - 1));
  assign w_bit_done  = (r_cnt == CW'(BIT_CYC - 1));

  always_comb begin
    w_rx_next   = r_rx_state;
    w_set_valid = 1'b0;
    w_set_err   = 1'b0;
    case (r_rx_state)
      RX_IDLE:  if (w_fall) w_rx_next = RX_START;
      RX_START: if (w_half_done) begin
                  if (!r_rx_sync) w_rx_next = RX_DATA;
                  else begin
                    w_rx_next = RX_IDLE;
                    w_set_err = 1'b1;
                  end
                end
      RX_DATA:  if (w_bit_done && r_bit == 3'd7) w_rx_next = RX_STOP;
      RX_STOP:  if (w_bit_done) begin
                  w_rx_next   = RX_IDLE;
                  w_set_valid = r_rx_sync;
                  w_set_err   = ~r_rx_sync;
                end
      default:  w_rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_state   <= RX_IDLE;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      r_rx_error   <= 1'b0;
      r_last_byte  <= 8'h00;
    end else begin
      r_rx_state   <= w_rx_next;
      r_byte_valid <= w_set_valid;
      r_rx_error   <= w_set_err;
      if (w_set_valid) r_last_byte <= r_shift;
      if (w_rx_next != r_rx_state) r_cnt <= '0;
      else if (r_rx_state == RX_DATA && w_bit_done) r_cnt <= '0;
      else if (r_rx_state != RX_IDLE) r_cnt <= r_cnt + CW'(1);
      if (r_rx_state == RX_START) r_bit <= '0;
      else if (r_rx_state == RX_DATA && w_bit_done) begin
        r_bit   <= r_bit + 3'd1;
        r_shift <= {r_rx_sync, r_shift[7:1]};
      end
    end
  end

  // Received bytes are acted on in the cycle byteValid is high, using the held lastByte.
  assign w_printable = (r_last_byte >= 8'h20) && (r_last_byte <= 8'h7E);
  assign w_cr        = r_byte_valid && (r_last_byte == 8'h0D);
  assign w_lf        = r_byte_valid && (r_last_byte == 8'h0A);
  assign w_ff        = r_byte_valid && (r_last_byte == 8'h0C);
  assign w_row_go    = w_lf && (r_clr_state != CLR_ALL);
  assign w_row_start = AW'((int'(r_wr_ptr) / COLS) * COLS);
  assign w_next_row  = AW'(((int'(r_wr_ptr) / COLS) + 1 >= ROWS) ? 0
                           : ((int'(r_wr_ptr) / COLS) + 1) * COLS);
  assign w_ptr_inc   = (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);

  // Byte writes win the single write port; the clear simply stalls for that cycle.
  assign w_byte_we  = r_byte_valid && w_printable;
  assign w_clr_we   = (r_clr_state != CLR_IDLE) && !w_byte_we;
  assign w_clr_last = ((r_clr_state == CLR_ROW) && (r_clr_cnt == AW'(COLS - 1))) ||
                      ((r_clr_state == CLR_ALL) && (r_clr_cnt == AW'(DEPTH - 1)));
  assign w_we       = w_byte_we || w_clr_we;
  assign w_waddr    = w_byte_we ? r_wr_ptr
                    : (r_clr_state == CLR_ROW) ? r_clr_base + r_clr_cnt : r_clr_cnt;
  assign w_wdata    = w_byte_we ? r_last_byte : 8'h20;

  always_comb begin
    w_clr_next = r_clr_state;
    if (w_ff) w_clr_next = CLR_ALL;
    else if (w_row_go) w_clr_next = CLR_ROW;
    else if (w_clr_we && w_clr_last) w_clr_next = CLR_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clr_state <= CLR_ALL;
      r_clr_cnt   <= '0;
      r_clr_base  <= '0;
      r_wr_ptr    <= '0;
    end else begin
      r_clr_state <= w_clr_next;
      if (w_ff) r_clr_cnt <= '0;
      else if (w_row_go) begin
        r_clr_cnt  <= '0;
        r_clr_base <= w_next_row;
      end else if (w_clr_we) r_clr_cnt <= w_clr_last ? '0 : r_clr_cnt + AW'(1);
      if (w_byte_we) r_wr_ptr <= w_ptr_inc;
      else if (w_cr) r_wr_ptr <= w_row_start;
      else if (w_lf) r_wr_ptr <= w_next_row;
      else if (w_ff) r_wr_ptr <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_char_out <= 8'h20;
    else r_char_out <= (r_clr_state == CLR_ALL) ? 8'h20 : r_mem[charAddress];
  end

endmodule

// File: tb/tb_uart_text_buffer.sv
// tb/tb_uart_text_buffer.sv - randomized self-checking bench for uart_text_buffer
module tb_uart_text_buffer;

  localparam int CLK_HZ  = 27000000;
  localparam int BAUD    = 421875;
  localparam int BIT_CYC = CLK_HZ / BAUD;
  localparam int HALF    = BIT_CYC / 2;
  localparam int COLS    = 16;
  localparam int ROWS    = 4;
  localparam int DEPTH   = ROWS * COLS;
  localparam int AW      = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          uartRx = 1'b1;
  logic [AW-1:0] charAddress = '0;
  logic [7:0]    charOutput;
  logic          byteValid;
  logic [7:0]    lastByte;
  logic          rxError;

  uart_text_buffer #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .reset(reset), .uartRx(uartRx), .charAddress(charAddress),
    .charOutput(charOutput), .byteValid(byteValid), .lastByte(lastByte), .rxError(rxError)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail = 0;
  int         valid_cnt = 0;
  int         err_cnt = 0;
  logic [7:0] rx_q[$];
  logic [7:0] model_mem[DEPTH];
  int         model_ptr;
  logic [7:0] obs_mem[DEPTH];
  int         last_dv, last_de;
  logic [7:0] last_got;

  always @(negedge clk) begin
    if (byteValid) begin
      valid_cnt++;
      rx_q.push_back(lastByte);
    end
    if (rxError) err_cnt++;
  end

  function automatic void model_clear_all();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h20;
    model_ptr = 0;
  endfunction

  function automatic void model_apply(input logic [7:0] b);
    int row;
    if (b >= 8'h20 && b <= 8'h7E) begin
      model_mem[model_ptr] = b;
      model_ptr = (model_ptr + 1) % DEPTH;
    end else if (b == 8'h0D) begin
      model_ptr = (model_ptr / COLS) * COLS;
    end else if (b == 8'h0A) begin
      row = (model_ptr / COLS + 1) % ROWS;
      model_ptr = row * COLS;
      for (int c = 0; c < COLS; c++) model_mem[model_ptr + c] = 8'h20;
    end else if (b == 8'h0C) begin
      model_clear_all();
    end
  endfunction

  task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
    @(negedge clk) uartRx = 1'b0;
    repeat (BIT_CYC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uartRx = b[i];
      repeat (BIT_CYC) @(negedge clk);
    end
    uartRx = stop_bit;
    repeat (BIT_CYC) @(negedge clk);
    uartRx = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int v0, e0;
    v0 = valid_cnt;
    e0 = err_cnt;
    rx_q.delete();
    drive_frame(b, 1'b1);
    repeat (2) @(negedge clk);
    last_dv  = valid_cnt - v0;
    last_de  = err_cnt - e0;
    last_got = (rx_q.size() > 0) ? rx_q[rx_q.size() - 1] : 8'hxx;
  endtask

  task automatic read_buffer();
    repeat (4) @(negedge clk);
    for (int a = 0; a < DEPTH; a++) begin
      charAddress = AW'(a);
      @(negedge clk);
      obs_mem[a] = charOutput;
    end
  endtask

  function automatic logic [7:0] rand_print();
    return 8'($urandom_range(8'h20, 8'h7E));
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({charOutput, byteValid, lastByte, rxError} !== {8'h20, 1'b0, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got out=%02h bv=%b lb=%02h err=%b required 20 0 00 0",
               charOutput, byteValid, lastByte, rxError);
    end
    reset = 1'b0;
    repeat (64) @(negedge clk);
    model_clear_all();
    read_buffer();
    for (int a = 0; a < DEPTH; a++) begin
      n_checks++;
      if (obs_mem[a] !== model_mem[a]) begin
        n_fail++;
        $display("FAIL reset_buffer addr %0d: got %02h required %02h", a, obs_mem[a], model_mem[a]);
      end
    end
  endtask

  task automatic test_single_byte();
    send_byte(8'h41);
    n_checks++;
    if (last_dv !== 1 || last_de !== 0 || last_got !== 8'h41 || lastByte !== 8'h41) begin
      n_fail++;
      $display("FAIL single_byte: got pulses=%0d errs=%0d byte=%02h held=%02h required 1 0 41 41",
               last_dv, last_de, last_got, lastByte);
    end
    model_apply(8'h41);
    send_byte(8'h42);
    model_apply(8'h42);
    read_buffer();
    for (int a = 0; a < DEPTH; a++) begin
      n_checks++;
      if (obs_mem[a] !== model_mem[a]) begin
        n_fail++;
        $display("FAIL single_byte_buffer addr %0d: got %02h required %02h", a, obs_mem[a], model_mem[a]);
      end
    end
  endtask

  task automatic test_row_wrap();
    send_byte(8'h0C);
    model_apply(8'h0C);
    for (int i = 0; i < 17; i++) begin
      send_byte(8'(8'h61 + i));
      n_checks++;
      if (last_dv !== 1 || last_got !== 8'(8'h61 + i)) begin
        n_fail++;
        $display("FAIL row_wrap_rx %0d: got pulses=%0d byte=%02h required 1 %02h",
                 i, last_dv, last_got, 8'(8'h61 + i));
      end
      model_apply(8'(8'h61 + i));
    end
    read_buffer();
    for (int a = 0; a < DEPTH; a++) begin
      n_checks++;
      if (obs_mem[a] !== model_mem[a]) begin
        n_fail++;
        $display("FAIL row_wrap_buffer addr %0d: got %02h required %02h", a, obs_mem[a], model_mem[a]);
      end
    end
  endtask

  task automatic test_lf_cr();
    logic [7:0] b;
    while (model_ptr != 50) begin
      b = rand_print();
      send_byte(b);
      model_apply(b);
    end
    send_byte(8'h0A);
    model_apply(8'h0A);
    read_buffer();
    for (int a = 0; a < DEPTH; a++) begin
      n_checks++;
      if (obs_mem[a] !== model_mem[a]) begin
        n_fail++;
        $display("FAIL lf_buffer addr %0d: got %02h required %02h", a, obs_mem[a], model_mem[a]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      send_byte(8'(8'h58 + i));
      model_apply(8'(8'h58 + i));
    end
    send_byte(8'h0D);
    model_apply(8'h0D);
    send_byte(8'h23);
    model_apply(8'h23);
    read_buffer();
    for (int a = 0; a < DEPTH; a++) begin
      n_checks++;
      if (obs_mem[a] !== model_mem[a]) begin
        n_fail++;
        $display("FAIL cr_buffer addr %0d: got %02h required %02h", a, obs_mem[a], model_mem[a]);
      end
    end
  endtask

  task automatic test_rx_errors();
    int v0, e0;
    v0 = valid_cnt;
    e0 = err_cnt;
    drive_frame(rand_print(), 1'b0);
    repeat (BIT_CYC) @(negedge clk);
    n_checks++;
    if (valid_cnt - v0 !== 0 || err_cnt - e0 !== 1) begin
      n_fail++;
      $display("FAIL framing_error: got pulses=%0d errs=%0d required 0 1", valid_cnt - v0, err_cnt - e0);
    end
    v0 = valid_cnt;
    e0 = err_cnt;
    @(negedge clk) uartRx = 1'b0;
    repeat (HALF / 2) @(negedge clk);
    uartRx = 1'b1;
    repeat (2 * BIT_CYC) @(negedge clk);
    n_checks++;
    if (valid_cnt - v0 !== 0 || err_cnt - e0 !== 1) begin
      n_fail++;
      $display("FAIL false_start: got pulses=%0d errs=%0d required 0 1", valid_cnt - v0, err_cnt - e0);
    end
    send_byte(8'h5A);
    n_checks++;
    if (last_dv !== 1 || last_de !== 0 || last_got !== 8'h5A) begin
      n_fail++;
      $display("FAIL after_glitch_rx: got pulses=%0d errs=%0d byte=%02h required 1 0 5a",
               last_dv, last_de, last_got);
    end
    model_apply(8'h5A);
    read_buffer();
    for (int a = 0; a < DEPTH; a++) begin
      n_checks++;
      if (obs_mem[a] !== model_mem[a]) begin
        n_fail++;
        $display("FAIL err_buffer addr %0d: got %02h required %02h", a, obs_mem[a], model_mem[a]);
      end
    end
  endtask

  task automatic test_reset_mid_byte();
    int v0, e0;
    logic [7:0] b;
    b = 8'hC3;
    v0 = valid_cnt;
    e0 = err_cnt;
    @(negedge clk) uartRx = 1'b0;
    repeat (BIT_CYC) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      uartRx = b[i];
      repeat (BIT_CYC) @(negedge clk);
    end
    uartRx = b[4];
    repeat (HALF) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({charOutput, byteValid, lastByte, rxError} !== {8'h20, 1'b0, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_byte_reset_outputs: got out=%02h bv=%b lb=%02h err=%b required 20 0 00 0",
               charOutput, byteValid, lastByte, rxError);
    end
    uartRx = 1'b1;
    reset = 1'b0;
    repeat (64) @(negedge clk);
    n_checks++;
    if (valid_cnt - v0 !== 0 || err_cnt - e0 !== 0) begin
      n_fail++;
      $display("FAIL mid_byte_pulses: got pulses=%0d errs=%0d required 0 0", valid_cnt - v0, err_cnt - e0);
    end
    model_clear_all();
    read_buffer();
    for (int a = 0; a < DEPTH; a++) begin
      n_checks++;
      if (obs_mem[a] !== model_mem[a]) begin
        n_fail++;
        $display("FAIL mid_byte_buffer addr %0d: got %02h required %02h", a, obs_mem[a], model_mem[a]);
      end
    end
    send_byte(8'h55);
    n_checks++;
    if (last_dv !== 1 || last_got !== 8'h55) begin
      n_fail++;
      $display("FAIL post_reset_rx: got pulses=%0d byte=%02h required 1 55", last_dv, last_got);
    end
    model_apply(8'h55);
    send_byte(8'h6D);
    model_apply(8'h6D);
    send_byte(8'h0C);
    model_apply(8'h0C);
    send_byte(8'h78);
    model_apply(8'h78);
    read_buffer();
    for (int a = 0; a < DEPTH; a++) begin
      n_checks++;
      if (obs_mem[a] !== model_mem[a]) begin
        n_fail++;
        $display("FAIL ff_buffer addr %0d: got %02h required %02h", a, obs_mem[a], model_mem[a]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 11))
        7:       b = 8'h0D;
        8:       b = 8'h0A;
        9:       b = 8'h0C;
        10:      b = 8'h7F;
        11:      b = 8'($urandom_range(8'h80, 8'hFF));
        default: b = rand_print();
      endcase
      send_byte(b);
      n_checks++;
      if (last_dv !== 1 || last_de !== 0 || last_got !== b) begin
        n_fail++;
        $display("FAIL back_to_back_rx %0d: got pulses=%0d errs=%0d byte=%02h required 1 0 %02h",
                 i, last_dv, last_de, last_got, b);
      end
      model_apply(b);
    end
    read_buffer();
    for (int a = 0; a < DEPTH; a++) begin
      n_checks++;
      if (obs_mem[a] !== model_mem[a]) begin
        n_fail++;
        $display("FAIL back_to_back_buffer addr %0d: got %02h required %02h", a, obs_mem[a], model_mem[a]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_row_wrap();
    test_lf_cr();
    test_rx_errors();
    test_reset_mid_byte();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
